// File: rtl/mmu_pipe_pkg.sv
// Shared definitions for the MMU translator and the data-memory / UART muxes.
package mmu_pipe_pkg;

  typedef enum logic [1:0] {
    BS_DATA  = 2'b00,
    BS_STACK = 2'b01,
    BS_UART  = 2'b10,
    BS_NONE  = 2'b11
  } block_sel_e;

  localparam int unsigned DEF_ADDR_W     = 16;
  localparam int unsigned DEF_DATA_BASE  = 32'h0000;
  localparam int unsigned DEF_DATA_SIZE  = 32;
  localparam int unsigned DEF_STACK_TOP  = 32'h0400;
  localparam int unsigned DEF_STACK_SIZE = 32;
  localparam int unsigned DEF_UART_BASE  = 32'h0800;
  localparam int unsigned DEF_UART_SIZE  = 32;
  localparam int unsigned DEF_FCNT_W     = 8;

  // Region enables packed as {uart, stack, data}; unmapped gives none.
  function automatic logic [2:0] region_onehot(input block_sel_e bs);
    case (bs)
      BS_DATA:  return 3'b001;
      BS_STACK: return 3'b010;
      BS_UART:  return 3'b100;
      default:  return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/mmu_pipe_if.sv
// Request/response handshake bus between the load/store unit and the MMU.
interface mmu_pipe_if #(
  parameter int unsigned ADDR_W = 16
) ();
  import mmu_pipe_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_write;

  logic              rsp_valid;
  logic              rsp_ready;
  block_sel_e        block_select;
  logic [ADDR_W-1:0] address_physical;
  logic              rsp_write;
  logic              DataEnable;
  logic              StackEnable;
  logic              UARTEnable;

  // Load/store unit side: issues requests, consumes responses.
  modport master (
    output req_valid, req_addr, req_write, rsp_ready,
    input  req_ready, rsp_valid, block_select, address_physical, rsp_write,
           DataEnable, StackEnable, UARTEnable
  );

  // MMU side.
  modport slave (
    input  req_valid, req_addr, req_write, rsp_ready,
    output req_ready, rsp_valid, block_select, address_physical, rsp_write,
           DataEnable, StackEnable, UARTEnable
  );
endinterface

// File: rtl/mmu_pipe_decode.sv
// Combinational region decode: priority data > stack > uart.
module mmu_decode import mmu_pipe_pkg::*; #(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DATA_BASE  = DEF_DATA_BASE,
  parameter int unsigned DATA_SIZE  = DEF_DATA_SIZE,
  parameter int unsigned STACK_TOP  = DEF_STACK_TOP,
  parameter int unsigned STACK_SIZE = DEF_STACK_SIZE,
  parameter int unsigned UART_BASE  = DEF_UART_BASE,
  parameter int unsigned UART_SIZE  = DEF_UART_SIZE
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              hit,
  output block_sel_e        block_select,
  output logic [ADDR_W-1:0] phys
);

  // One extra bit: an address below a region base wraps to >= 2**ADDR_W,
  // which is larger than any legal region size, so a single unsigned
  // "offset < size" test covers both bounds without wrapping.
  localparam int unsigned W = ADDR_W + 1;
  typedef logic [W-1:0] ext_t;

  ext_t a_x;
  ext_t off_data;
  ext_t off_stack;
  ext_t off_uart;

  assign a_x       = {1'b0, addr};
  assign off_data  = a_x - ext_t'(DATA_BASE);
  assign off_stack = ext_t'(STACK_TOP) - a_x;
  assign off_uart  = a_x - ext_t'(UART_BASE);

  // Select the highest-priority region that contains the address.
  // NOTE: every output gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    hit          = 1'b0;
    block_select = BS_NONE;
    phys         = '0;
    if (off_data < ext_t'(DATA_SIZE)) begin
      hit          = 1'b1;
      block_select = BS_DATA;
      phys         = off_data[ADDR_W-1:0];
    end else if (off_stack < ext_t'(STACK_SIZE)) begin
      hit          = 1'b1;
      block_select = BS_STACK;
      phys         = off_stack[ADDR_W-1:0];
    end else if (off_uart < ext_t'(UART_SIZE)) begin
      hit          = 1'b1;
      block_select = BS_UART;
      phys         = off_uart[ADDR_W-1:0];
    end
  end

endmodule

// File: rtl/mmu_pipe.sv
// One-stage registered address translator with valid/ready flow control,
// UART-full back-pressure on stores and sticky fault capture.
module mmu_pipe import mmu_pipe_pkg::*; #(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DATA_BASE  = DEF_DATA_BASE,
  parameter int unsigned DATA_SIZE  = DEF_DATA_SIZE,
  parameter int unsigned STACK_TOP  = DEF_STACK_TOP,
  parameter int unsigned STACK_SIZE = DEF_STACK_SIZE,
  parameter int unsigned UART_BASE  = DEF_UART_BASE,
  parameter int unsigned UART_SIZE  = DEF_UART_SIZE,
  parameter int unsigned FCNT_W     = DEF_FCNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  mmu_pipe_if.slave         bus,
  input  logic              uart_full,
  output logic              fault,
  output logic              fault_sticky,
  output logic [ADDR_W-1:0] fault_addr,
  output logic [FCNT_W-1:0] fault_count,
  input  logic              fault_clear
);

  typedef struct packed {
    block_sel_e        bs;
    logic [ADDR_W-1:0] phys;
    logic              write;
    logic [2:0]        en;
    logic              fault;
  } rsp_t;

  logic              dec_hit;
  block_sel_e        dec_bs;
  logic [ADDR_W-1:0] dec_phys;

  logic              uart_stall;
  logic              req_ready;
  logic              accept;
  logic              accept_fault;

  logic              rsp_valid_d, rsp_valid_q;
  rsp_t              rsp_d, rsp_q;
  logic              sticky_d, sticky_q;
  logic [ADDR_W-1:0] faddr_d, faddr_q;
  logic [FCNT_W-1:0] fcnt_d, fcnt_q;

  mmu_decode #(
    .ADDR_W    (ADDR_W),
    .DATA_BASE (DATA_BASE),
    .DATA_SIZE (DATA_SIZE),
    .STACK_TOP (STACK_TOP),
    .STACK_SIZE(STACK_SIZE),
    .UART_BASE (UART_BASE),
    .UART_SIZE (UART_SIZE)
  ) u_decode (
    .addr        (bus.req_addr),
    .hit         (dec_hit),
    .block_select(dec_bs),
    .phys        (dec_phys)
  );

  // Handshake: stores to a full UART stall; otherwise accept when the
  // output register is empty or being drained this cycle.
  always_comb begin
    uart_stall   = bus.req_valid && (dec_bs == BS_UART) && bus.req_write && uart_full;
    req_ready    = !uart_stall && (!rsp_valid_q || bus.rsp_ready);
    accept       = bus.req_valid && req_ready;
    accept_fault = accept && !dec_hit;
  end

  // Output register next state: load on accept, drop valid on consume, else hold.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_d       = rsp_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_d.bs    = dec_bs;
      rsp_d.phys  = dec_phys;
      rsp_d.write = bus.req_write;
      rsp_d.en    = region_onehot(dec_bs);
      rsp_d.fault = !dec_hit;
    end else if (bus.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // Fault tracking; a fault accepted in the clearing cycle survives the clear.
  always_comb begin
    sticky_d = sticky_q;
    faddr_d  = faddr_q;
    fcnt_d   = fcnt_q;
    if (fault_clear) begin
      sticky_d = accept_fault;
      faddr_d  = accept_fault ? bus.req_addr : '0;
      fcnt_d   = accept_fault ? FCNT_W'(1) : '0;
    end else if (accept_fault) begin
      if (fcnt_q != '1) fcnt_d = fcnt_q + FCNT_W'(1);
      if (!sticky_q) begin
        sticky_d = 1'b1;
        faddr_d  = bus.req_addr;
      end
    end
  end

  // State registers with synchronous active-low reset.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
      sticky_q    <= 1'b0;
      faddr_q     <= '0;
      fcnt_q      <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_q       <= rsp_d;
      sticky_q    <= sticky_d;
      faddr_q     <= faddr_d;
      fcnt_q      <= fcnt_d;
    end
  end

  assign bus.req_ready        = req_ready;
  assign bus.rsp_valid        = rsp_valid_q;
  assign bus.block_select     = rsp_q.bs;
  assign bus.address_physical = rsp_q.phys;
  assign bus.rsp_write        = rsp_q.write;
  assign bus.DataEnable       = rsp_q.en[0];
  assign bus.StackEnable      = rsp_q.en[1];
  assign bus.UARTEnable       = rsp_q.en[2];
  assign fault                = rsp_q.fault;
  assign fault_sticky         = sticky_q;
  assign fault_addr           = faddr_q;
  assign fault_count          = fcnt_q;

endmodule

// File: tb/tb_mmu_pipe.sv
// Self-checking bench for mmu_pipe: directed scenarios plus randomized
// traffic, all compared against a region-arithmetic reference model.
module tb_mmu_pipe;

  localparam int DATA_BASE  = 'h0000;
  localparam int DATA_SIZE  = 32;
  localparam int STACK_TOP  = 'h0400;
  localparam int STACK_SIZE = 32;
  localparam int UART_BASE  = 'h0800;
  localparam int UART_SIZE  = 32;
  localparam int CNT_MAX    = 255;

  typedef struct {
    int bs;
    int phys;
    bit write;
    int en;
    bit fault;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        uart_full = 1'b0;
  logic        fault_clear = 1'b0;
  logic        fault;
  logic        fault_sticky;
  logic [15:0] fault_addr;
  logic [7:0]  fault_count;

  mmu_pipe_if #(.ADDR_W(16)) bus ();

  mmu_pipe dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .uart_full   (uart_full),
    .fault       (fault),
    .fault_sticky(fault_sticky),
    .fault_addr  (fault_addr),
    .fault_count (fault_count),
    .fault_clear (fault_clear)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference translation from the region rules, with plain integer arithmetic.
  function automatic exp_t ref_xlate(input int a, input bit w);
    exp_t r;
    r.write = w;
    r.bs = 3; r.phys = 0; r.en = 0; r.fault = 1'b1;
    if (a >= DATA_BASE && a < DATA_BASE + DATA_SIZE) begin
      r.bs = 0; r.phys = a - DATA_BASE; r.en = 1; r.fault = 1'b0;
    end else if (a <= STACK_TOP && a > STACK_TOP - STACK_SIZE) begin
      r.bs = 1; r.phys = STACK_TOP - a; r.en = 2; r.fault = 1'b0;
    end else if (a >= UART_BASE && a < UART_BASE + UART_SIZE) begin
      r.bs = 2; r.phys = a - UART_BASE; r.en = 4; r.fault = 1'b0;
    end
    return r;
  endfunction

  // Stimulus controls for the background driver of rsp_ready/uart_full/fault_clear.
  int rdy_mode = 0;   // 0: always 1, 1: toggle, 2: random, 3: always 0
  bit rand_on  = 1'b0;
  bit uf_set   = 1'b0;
  bit fc_set   = 1'b0;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       bus.rsp_ready = 1'b1;
      1:       bus.rsp_ready = ~bus.rsp_ready;
      2:       bus.rsp_ready = 1'($urandom_range(0, 1));
      default: bus.rsp_ready = 1'b0;
    endcase
    uart_full   = rand_on ? ($urandom_range(0, 3) == 0) : uf_set;
    fault_clear = rand_on ? ($urandom_range(0, 15) == 0) : fc_set;
  end

  // Scoreboard: expected responses in order, plus the fault-tracking model.
  exp_t exp_q[$];
  bit   model_on = 1'b0;
  int   m_cnt = 0;
  bit   m_sticky = 1'b0;
  int   m_addr = 0;
  int   dut_rsp_cnt = 0;

  always @(negedge clk) begin
    exp_t e, n;
    bit   stall, exp_ready, acc;
    if (!rst_n) begin
      exp_q.delete();
      m_cnt = 0; m_sticky = 1'b0; m_addr = 0;
      model_on = 1'b1;
    end else if (model_on) begin
      check("rsp_valid", bus.rsp_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        e = exp_q[0];
        check("block_select", bus.block_select, e.bs);
        check("phys", bus.address_physical, e.phys);
        check("rsp_write", bus.rsp_write, e.write);
        check("enables", {bus.UARTEnable, bus.StackEnable, bus.DataEnable}, e.en);
        check("fault", fault, e.fault);
      end
      n = ref_xlate(int'(bus.req_addr), bus.req_write);
      stall = bus.req_valid && n.bs == 2 && bus.req_write && uart_full;
      exp_ready = !stall && (exp_q.size() == 0 || bus.rsp_ready);
      check("req_ready", bus.req_ready, exp_ready);
      check("fault_sticky", fault_sticky, m_sticky);
      check("fault_addr", fault_addr, m_addr);
      check("fault_count", fault_count, m_cnt);
      if (bus.rsp_valid && bus.rsp_ready) dut_rsp_cnt++;
      if (exp_q.size() != 0 && bus.rsp_ready) void'(exp_q.pop_front());
      acc = bus.req_valid && exp_ready;
      if (acc) exp_q.push_back(n);
      if (fault_clear) begin
        if (acc && n.fault) begin m_cnt = 1; m_sticky = 1'b1; m_addr = int'(bus.req_addr); end
        else begin m_cnt = 0; m_sticky = 1'b0; m_addr = 0; end
      end else if (acc && n.fault) begin
        if (m_cnt < CNT_MAX) m_cnt++;
        if (!m_sticky) begin m_sticky = 1'b1; m_addr = int'(bus.req_addr); end
      end
    end
  end

  // Drivers: called at posedge+2, return at posedge+2 after the accepting edge.
  task automatic idle(input int n);
    bus.req_valid = 1'b0;
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic send(input logic [15:0] a, input logic w);
    int  waited = 0;
    bit  done = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.req_write = w;
    while (!done) begin
      @(negedge clk);
      if (bus.req_ready) done = 1'b1;
      else if (++waited > 50) begin
        check("accept_timeout", 32'(waited), 0);
        done = 1'b1;
      end
      @(posedge clk); #2;
    end
  endtask

  function automatic logic [15:0] rand_addr();
    case ($urandom_range(0, 4))
      0:       return 16'($urandom_range(0, 40));
      1:       return 16'($urandom_range('h3D0, 'h410));
      2:       return 16'($urandom_range('h7F0, 'h830));
      3:       return 16'($urandom_range(0, 31));
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [15:0] singles [5] = '{16'h0000, 16'h001F, 16'h0400, 16'h03E1, 16'h0805};
  logic [15:0] bounds  [5] = '{16'h0020, 16'h03E0, 16'h0401, 16'h0820, 16'hFFFF};

  initial begin
    int cnt0;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_write = 1'b0;
    bus.rsp_ready = 1'b1;

    // Reset and reset-state checks.
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_block_select", bus.block_select, 0);
    check("rst_phys", bus.address_physical, 0);
    check("rst_enables", {bus.UARTEnable, bus.StackEnable, bus.DataEnable}, 0);
    check("rst_fault", fault, 0);
    check("rst_req_ready", bus.req_ready, 1);
    @(posedge clk); #2;

    // Mapped singles, one at a time.
    foreach (singles[i]) begin
      send(singles[i], 1'b0);
      idle(1);
    end
    send(16'h0805, 1'b0);
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("uart_single_bs", bus.block_select, 2);
    check("uart_single_phys", bus.address_physical, 5);
    check("uart_single_en", bus.UARTEnable, 1);
    @(posedge clk); #2;

    // Boundary addresses just outside each region.
    foreach (bounds[i]) begin
      send(bounds[i], 1'b0);
      idle(1);
    end
    @(negedge clk);
    check("bound_sticky", fault_sticky, 1);
    check("bound_fault_addr", fault_addr, 'h0020);
    check("bound_fault_count", fault_count, 5);
    @(posedge clk); #2;

    // UART store stalls while full; UART load does not.
    uf_set = 1'b1;
    idle(1);
    bus.req_valid = 1'b1; bus.req_addr = 16'h0800; bus.req_write = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("uart_stall_ready", bus.req_ready, 0);
      check("uart_stall_no_rsp", bus.rsp_valid, 0);
      if (i == 3) uf_set = 1'b0;
      @(posedge clk); #2;
    end
    send(16'h0800, 1'b1);
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("uart_store_rsp", bus.rsp_valid, 1);
    check("uart_store_write", bus.rsp_write, 1);
    @(posedge clk); #2;
    uf_set = 1'b1;
    idle(1);
    bus.req_valid = 1'b1; bus.req_addr = 16'h0800; bus.req_write = 1'b0;
    @(negedge clk);
    check("uart_load_ready", bus.req_ready, 1);
    @(posedge clk); #2;
    uf_set = 1'b0;
    idle(2);

    // Back-to-back stream with rsp_ready toggling.
    cnt0 = dut_rsp_cnt;
    rdy_mode = 1;
    for (int i = 0; i < 8; i++) send(16'(i * 3), 1'(i & 1));
    bus.req_valid = 1'b0;
    rdy_mode = 0;
    idle(4);
    check("stream_rsp_count", 32'(dut_rsp_cnt - cnt0), 8);

    // Randomized traffic with random back-pressure and clears.
    rdy_mode = 2;
    rand_on = 1'b1;
    for (int i = 0; i < 200; i++) send(rand_addr(), 1'($urandom_range(0, 1)));
    rand_on = 1'b0;
    rdy_mode = 0;
    idle(4);

    // Counter saturation, then clear coinciding with an accepted fault.
    for (int i = 0; i < 300; i++) send(16'h1000 + 16'(i), 1'b0);
    idle(1);
    @(negedge clk);
    check("sat_count", fault_count, 255);
    @(posedge clk); #2;
    fc_set = 1'b1;
    idle(1);
    fc_set = 1'b0;
    send(16'h0900, 1'b0);
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("clr_count", fault_count, 1);
    check("clr_sticky", fault_sticky, 1);
    check("clr_addr", fault_addr, 'h0900);
    @(posedge clk); #2;

    // Reset while a response is held under back-pressure.
    rdy_mode = 3;
    idle(1);
    send(16'h0001, 1'b0);
    idle(2);
    @(negedge clk);
    check("held_rsp_valid", bus.rsp_valid, 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_rsp_valid", bus.rsp_valid, 0);
    check("midrst_sticky", fault_sticky, 0);
    check("midrst_count", fault_count, 0);
    check("midrst_addr", fault_addr, 0);
    check("midrst_req_ready", bus.req_ready, 1);
    @(posedge clk); #2;
    rdy_mode = 0;
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mmu_pipe.md
Name: mmu_pipe

Overview:
- Registered, handshaked virtual-to-physical address translator between the CPU load/store unit and the data RAM, stack RAM and UART TX blocks.
- Decodes three parametrised regions:
  - .data and .uart grow upward.
  - .stack grows downward from its top address.
- Adds one pipeline stage with valid/ready flow control, UART-full back-pressure on writes, and sticky fault capture for unmapped addresses.

Parameters:
- ADDR_W, 16, virtual and physical address width
- DATA_BASE, 16'h0000, lowest .data address
- DATA_SIZE, 32, .data words
- STACK_TOP, 16'h0400, highest (inclusive) .stack address
- STACK_SIZE, 32, .stack words
- UART_BASE, 16'h0800, lowest .uart address
- UART_SIZE, 32, .uart words
- FCNT_W, 8, fault counter width

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous reset, active low
- req_valid  in  1  request present
- req_ready  out  1  request accepted this cycle when req_valid&&req_ready
- req_addr  in  ADDR_W  virtual address
- req_write  in  1  1=store, 0=load
- uart_full  in  1  UART TX FIFO full
- rsp_valid  out  1  translated result held
- rsp_ready  in  1  consumer takes result
- block_select  out  2  00 data, 01 stack, 10 uart, 11 unmapped
- address_physical  out  ADDR_W  region-relative word index
- rsp_write  out  1  registered copy of req_write
- DataEnable  out  1  one-hot region enable
- StackEnable  out  1  one-hot region enable
- UARTEnable  out  1  one-hot region enable
- fault  out  1  registered: current rsp is unmapped
- fault_sticky  out  1  set on first fault, held until cleared
- fault_addr  out  ADDR_W  address of first fault since clear
- fault_count  out  FCNT_W  saturating fault count
- fault_clear  in  1  clears sticky, addr and count

Behaviour:
- Reset (rst_n low at posedge): all outputs and registers 0; block_select=00; req_ready evaluates to 1 after reset. Reset mid-transfer discards the held response.
- Decode is combinational on req_addr, with priority data > stack > uart:
  - data: DATA_BASE <= a < DATA_BASE+DATA_SIZE; phys = a-DATA_BASE.
  - stack: STACK_TOP-STACK_SIZE < a <= STACK_TOP; phys = STACK_TOP-a, so STACK_TOP maps to 0.
  - uart: UART_BASE <= a < UART_BASE+UART_SIZE; phys = a-UART_BASE.
  - none: block_select=11, phys=0, all enables 0, fault=1.
- Compare in ADDR_W+1 bits; bounds must not wrap.
- uart_stall = req_valid && decoded uart && req_write && uart_full. UART loads never stall.
- req_ready = !uart_stall && (!rsp_valid || rsp_ready). The ready path is combinational through rsp_ready; this is the accepted, documented path.
- Accept (req_valid&&req_ready): the output register loads decode results, rsp_write and fault; rsp_valid=1 the next cycle. Latency is exactly 1 cycle.
- rsp_valid && !rsp_ready: all rsp outputs hold stable.
- rsp_ready && no accept: rsp_valid=0 next cycle; outputs other than rsp_valid are don't-care but held.
- Simultaneous consume and accept: new data loads with no bubble, giving full throughput.
- Fault tracking updates on accept of an unmapped address:
  - fault_count increments, saturating at all-ones.
  - If fault_sticky==0, set fault_sticky and capture fault_addr.
- fault_clear: the same-cycle accepted fault wins. Counter=1, sticky=1, addr=new address. Otherwise all three clear.
- Enables are only meaningful when rsp_valid=1. Consumers must gate on rsp_valid.

Decomposition:
- Shared package/include mmu_defs: block_select encodings (BS_DATA, BS_STACK, BS_UART, BS_NONE) and default base/size constants, reused by the data-memory and UART muxes.
- Sub-module mmu_decode: purely combinational decode producing {hit, block_select, phys}. mmu_pipe holds the handshake, output register and fault logic.

Test Plan:
- Reset, then single requests 0x0000, 0x001F, 0x0400, 0x03E1, 0x0805 with rsp_ready=1 → one cycle later:
  - block_select 00/00/01/01/10
  - phys 0/31/0/31/5
  - correct one-hot enable; fault=0
- Boundaries 0x0020, 0x03E0, 0x0401, 0x0820, 0xFFFF → block_select=11, all enables 0, fault=1. Sticky set with fault_addr=0x0020 and fault_count=5.
- Store to 0x0800 with uart_full=1 for 4 cycles → req_ready=0 and no rsp for those cycles; uart_full drops → accept, rsp_valid next cycle. Load to 0x0800 with uart_full=1 → accepted immediately.
- Back-to-back stream of 8 requests, rsp_ready toggling 1,0,1,0 → no lost or duplicated responses, order preserved, outputs stable while stalled, throughput 1/cycle when rsp_ready=1.
- 300 faulting requests, then fault_clear together with an accepted fault at 0x0900 → count saturates at 255; after clear, count=1, sticky=1, fault_addr=0x0900.
- rst_n low for 1 cycle while rsp_valid=1 and rsp_ready=0 → rsp_valid=0, fault registers 0, req_ready=1 the next cycle.
